// File: rtl/uart_rx_reg_if.sv
// APB register front-end for a UART receiver: RXDATA pop handshake, sticky error status and CTRL.
// Interrupt support (CTRL.ie_rx/ie_err and the irq flop) is built only when UART_RX_IRQ_EN is defined.
module uart_rx_reg_if #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  parity_err,
    input  logic                  overflow,
    output logic                  rx_data_reg_rd,
    output logic                  data_bits,
    output logic                  parity_en,
    output logic                  parity_odd0_even1,
    output logic                  irq
);

    typedef enum logic [1:0] {StIdle, StPop, StCapt, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       data_bits_q, data_bits_d;
    logic       parity_en_q, parity_en_d;
    logic       parity_odd_q, parity_odd_d;
    logic       perr_q, perr_d;
    logic       ovf_q, ovf_d;
    logic       parity_err_q;
    logic       ie_rx, ie_err;

    logic       access, wr_en, rx_rd_req, ctrl_wr, stat_wr, perr_set;
    logic [1:0] idx;

    logic       unused_bits;
    assign unused_bits = ^{PWDATA, PADDR};

    assign idx       = PADDR[3:2];
    assign access    = PSEL & PENABLE;
    assign rx_rd_req = access & ~PWRITE & (idx == 2'd0) & rx_ready;
    assign wr_en     = access & PWRITE & PREADY;
    assign ctrl_wr   = wr_en & (idx == 2'd2);
    assign stat_wr   = wr_en & (idx == 2'd1);
    // Rising edge of parity_err, qualified by parity enable.
    assign perr_set  = parity_en_q & parity_err & ~parity_err_q;

    always_comb begin
        state_d        = state_q;
        PREADY         = 1'b1;
        rx_data_reg_rd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_rd_req) begin
                    state_d = StPop;
                    PREADY  = 1'b0;
                end
            end
            StPop: begin
                rx_data_reg_rd = 1'b1;
                PREADY         = 1'b0;
                state_d        = StCapt;
            end
            StCapt: begin
                PREADY  = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hold_d       = (state_q == StCapt) ? rx_data : hold_q;
        data_bits_d  = ctrl_wr ? PWDATA[0] : data_bits_q;
        parity_en_d  = ctrl_wr ? PWDATA[1] : parity_en_q;
        parity_odd_d = ctrl_wr ? PWDATA[2] : parity_odd_q;
        // Set wins over a simultaneous W1C clear.
        perr_d       = perr_set | (perr_q & ~(stat_wr & PWDATA[1]));
        ovf_d        = overflow | (ovf_q & ~(stat_wr & PWDATA[2]));
    end

    always_comb begin
        PRDATA  = 32'h0;
        PSLVERR = 1'b0;
        if (access && PREADY) begin
            PSLVERR = (idx == 2'd3);
            if (state_q == StDone) begin
                PRDATA = {24'h0, hold_q};
            end else if (!PWRITE) begin
                unique case (idx)
                    2'd1:    PRDATA = {29'h0, ovf_q, perr_q, rx_ready};
                    2'd2:    PRDATA = {27'h0, ie_err, ie_rx, parity_odd_q, parity_en_q,
                                       data_bits_q};
                    default: PRDATA = 32'h0;
                endcase
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= StIdle;
            hold_q       <= 8'h0;
            data_bits_q  <= 1'b1;
            parity_en_q  <= 1'b0;
            parity_odd_q <= 1'b0;
            perr_q       <= 1'b0;
            ovf_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            data_bits_q  <= data_bits_d;
            parity_en_q  <= parity_en_d;
            parity_odd_q <= parity_odd_d;
            perr_q       <= perr_d;
            ovf_q        <= ovf_d;
            parity_err_q <= parity_err;
        end
    end

`ifdef UART_RX_IRQ_EN
    logic ie_rx_q, ie_rx_d, ie_err_q, ie_err_d, irq_q, irq_d;

    always_comb begin
        ie_rx_d  = ctrl_wr ? PWDATA[3] : ie_rx_q;
        ie_err_d = ctrl_wr ? PWDATA[4] : ie_err_q;
        irq_d    = (ie_rx_q & rx_ready) | (ie_err_q & (perr_q | ovf_q));
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ie_rx_q  <= 1'b0;
            ie_err_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ie_rx_q  <= ie_rx_d;
            ie_err_q <= ie_err_d;
            irq_q    <= irq_d;
        end
    end

    assign ie_rx  = ie_rx_q;
    assign ie_err = ie_err_q;
    assign irq    = irq_q;
`else
    assign ie_rx  = 1'b0;
    assign ie_err = 1'b0;
    assign irq    = 1'b0;
`endif

    assign data_bits         = data_bits_q;
    assign parity_en         = parity_en_q;
    assign parity_odd0_even1 = parity_odd_q;

endmodule

// File: tb/tb_uart_rx_reg_if.sv
// Self-checking bench for uart_rx_reg_if; expected read results flow through a scoreboard queue.
// Build with or without UART_RX_IRQ_EN; the interrupt scenario follows the macro.
module tb_uart_rx_reg_if;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [3:0]  PADDR = 4'h0;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_ready = 1'b0, parity_err = 1'b0, overflow = 1'b0;
    logic        rx_data_reg_rd, data_bits, parity_en, parity_odd0_even1, irq;

    int tests_run = 0;
    int tests_failed = 0;
    int pop_cnt = 0;

    typedef struct {
        logic [31:0] data;
        logic        slverr;
        int          waits;
        int          pops;
    } exp_t;
    exp_t sb[$];

    uart_rx_reg_if #(.ADDR_WIDTH(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .rx_data(rx_data), .rx_ready(rx_ready), .parity_err(parity_err), .overflow(overflow),
        .rx_data_reg_rd(rx_data_reg_rd), .data_bits(data_bits), .parity_en(parity_en),
        .parity_odd0_even1(parity_odd0_even1), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) if (rx_data_reg_rd === 1'b1) pop_cnt <= pop_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic slverr, output int waits, output int pops);
        int p0;
        bit done;
        @(posedge ACLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge ACLK); #1;
        PENABLE = 1'b1;
        p0 = pop_cnt;
        waits = 0;
        done = 1'b0;
        data = 32'h0;
        slverr = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge ACLK);
            if (PREADY === 1'b1) begin
                data = PRDATA;
                slverr = PSLVERR;
                done = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!done) waits = -1;
        @(posedge ACLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        pops = pop_cnt - p0;
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] wdata, input logic ovf);
        bit done;
        @(posedge ACLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = wdata;
        @(posedge ACLK); #1;
        PENABLE = 1'b1;
        overflow = ovf;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge ACLK);
            if (PREADY === 1'b1) done = 1'b1;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL write_timeout: addr %h got PREADY low, want PREADY high", addr);
        end
        @(posedge ACLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; overflow = 1'b0;
    endtask

    // Register read checked against the head of the scoreboard.
    task automatic read_and_score(input string name, input logic [3:0] addr);
        logic [31:0] d;
        logic        se;
        int          w, p;
        exp_t        e;
        apb_read(addr, d, se, w, p);
        e = sb.pop_front();
        tests_run++;
        if (d !== e.data || se !== e.slverr || w != e.waits || p != e.pops) begin
            tests_failed++;
            $display("FAIL %s: got data=%h slverr=%b waits=%0d pops=%0d, want data=%h slverr=%b waits=%0d pops=%0d",
                     name, d, se, w, p, e.data, e.slverr, e.waits, e.pops);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        tests_run++;
        if ({rx_data_reg_rd, irq, data_bits, parity_en, parity_odd0_even1, PREADY} !== 6'b001001) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rd=%b irq=%b db=%b pe=%b po=%b rdy=%b, want 0 0 1 0 0 1",
                     rx_data_reg_rd, irq, data_bits, parity_en, parity_odd0_even1, PREADY);
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        sb.push_back('{32'h01, 1'b0, 0, 0});
        read_and_score("reset_ctrl", 4'h8);
        sb.push_back('{32'h00, 1'b0, 0, 0});
        read_and_score("reset_status", 4'h4);
    endtask

    task automatic test_rxdata_pop();
        rx_data = 8'hA5;
        rx_ready = 1'b1;
        sb.push_back('{32'hA5, 1'b0, 3, 1});
        read_and_score("rxdata_pop", 4'h0);
        rx_ready = 1'b0;
        rx_data = 8'h5A;
        sb.push_back('{32'h00, 1'b0, 0, 0});
        read_and_score("rxdata_empty", 4'h0);
    endtask

    task automatic test_overflow();
        @(posedge ACLK); #1;
        overflow = 1'b1;
        @(posedge ACLK); #1;
        overflow = 1'b0;
        sb.push_back('{32'h4, 1'b0, 0, 0});
        read_and_score("ovf_set", 4'h4);
        apb_write(4'h4, 32'h4, 1'b0);
        sb.push_back('{32'h0, 1'b0, 0, 0});
        read_and_score("ovf_w1c", 4'h4);
        apb_write(4'h4, 32'h4, 1'b1);
        sb.push_back('{32'h4, 1'b0, 0, 0});
        read_and_score("ovf_set_wins", 4'h4);
        apb_write(4'h4, 32'h4, 1'b0);
        sb.push_back('{32'h0, 1'b0, 0, 0});
        read_and_score("ovf_clear_again", 4'h4);
    endtask

    task automatic test_parity();
        apb_write(4'h8, 32'h3, 1'b0);
        @(negedge ACLK);
        tests_run++;
        if ({data_bits, parity_en, parity_odd0_even1} !== 3'b110) begin
            tests_failed++;
            $display("FAIL ctrl_outputs: got db=%b pe=%b po=%b, want 1 1 0",
                     data_bits, parity_en, parity_odd0_even1);
        end
        @(posedge ACLK); #1;
        parity_err = 1'b1;
        repeat (2) @(posedge ACLK); #1;
        parity_err = 1'b0;
        sb.push_back('{32'h2, 1'b0, 0, 0});
        read_and_score("perr_set", 4'h4);
        apb_write(4'h4, 32'h2, 1'b0);
        sb.push_back('{32'h0, 1'b0, 0, 0});
        read_and_score("perr_w1c", 4'h4);
        apb_write(4'h8, 32'h1, 1'b0);
        @(posedge ACLK); #1;
        parity_err = 1'b1;
        repeat (2) @(posedge ACLK); #1;
        parity_err = 1'b0;
        sb.push_back('{32'h0, 1'b0, 0, 0});
        read_and_score("perr_disabled", 4'h4);
    endtask

    task automatic test_irq();
`ifdef UART_RX_IRQ_EN
        logic [3:0] seen;
        apb_write(4'h8, 32'h09, 1'b0);
        sb.push_back('{32'h09, 1'b0, 0, 0});
        read_and_score("irq_ctrl_rb", 4'h8);
        @(posedge ACLK); #1;
        rx_ready = 1'b1;
        @(negedge ACLK); seen[0] = irq;
        @(negedge ACLK); seen[1] = irq;
        @(posedge ACLK); #1;
        rx_ready = 1'b0;
        @(negedge ACLK); seen[2] = irq;
        @(negedge ACLK); seen[3] = irq;
        tests_run++;
        if (seen !== 4'b0110) begin
            tests_failed++;
            $display("FAIL irq_latency: got irq seq(3..0)=%b, want 0110", seen);
        end
        apb_write(4'h8, 32'h01, 1'b0);
`else
        logic [3:0] seen;
        apb_write(4'h8, 32'h19, 1'b0);
        sb.push_back('{32'h01, 1'b0, 0, 0});
        read_and_score("noirq_ctrl_rb", 4'h8);
        @(posedge ACLK); #1;
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            seen[i] = irq;
        end
        rx_ready = 1'b0;
        tests_run++;
        if (seen !== 4'b0000) begin
            tests_failed++;
            $display("FAIL noirq_tied: got irq seq=%b, want 0000", seen);
        end
`endif
    endtask

    task automatic test_reserved();
        sb.push_back('{32'h0, 1'b1, 0, 0});
        read_and_score("reserved_slverr", 4'hC);
        sb.push_back('{32'h01, 1'b0, 0, 0});
        read_and_score("after_reserved_ok", 4'h8);
    endtask

    task automatic test_reset_during_pop();
        int  p0;
        logic rd_pop, rd_after, rdy_after;
        apb_write(4'h8, 32'h07, 1'b0);
        rx_data = 8'h3C;
        rx_ready = 1'b1;
        @(posedge ACLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
        @(posedge ACLK); #1;
        PENABLE = 1'b1;
        p0 = pop_cnt;
        @(negedge ACLK);
        @(negedge ACLK);
        rd_pop = rx_data_reg_rd;
        #1;
        ARESET = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0;
        #1;
        rd_after = rx_data_reg_rd;
        rdy_after = PREADY;
        tests_run++;
        if ({rd_pop, rd_after, rdy_after} !== 3'b101) begin
            tests_failed++;
            $display("FAIL reset_in_pop: got rd_pop=%b rd_after=%b ready_after=%b, want 1 0 1",
                     rd_pop, rd_after, rdy_after);
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        repeat (3) @(posedge ACLK); #1;
        tests_run++;
        if (pop_cnt - p0 != 1) begin
            tests_failed++;
            $display("FAIL pop_not_replayed: got %0d pops, want 1", pop_cnt - p0);
        end
        sb.push_back('{32'h01, 1'b0, 0, 0});
        read_and_score("ctrl_after_abort", 4'h8);
        sb.push_back('{32'h3C, 1'b0, 3, 1});
        read_and_score("rxdata_after_abort", 4'h0);
        rx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rxdata_pop();
        test_overflow();
        test_parity();
        test_irq();
        test_reserved();
        test_reset_during_pop();
        repeat (2) @(posedge ACLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
